// File: rtl/ysyx_24110026_lsu.sv
// Load/store unit: turns the execute result into at most one memory access and a write-back packet.
// Non-pipelined; a new operation is accepted only after the previous packet is taken.
`timescale 1ns/1ps
module ysyx_24110026_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wen,
  output logic [3:0]  out_rd,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e      state_q;
  logic        load_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        misaligned;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] rshift;
  logic [31:0] load_data;

  assign in_ready = (state_q == StIdle) && !rst;

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 4'b1111;
    lane_wdata = in_wdata;
    case (in_size)
      2'b00: begin
        lane_mask  = 4'b0001 << in_addr[1:0];
        lane_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = in_addr[0];
        lane_mask  = 4'b0011 << in_addr[1:0];
        lane_wdata = {2{in_wdata[15:0]}};
      end
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Extraction uses the captured request attributes, not the live inputs.
  always_comb begin
    rshift = mem_resp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = unsigned_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_data = mem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      load_q        <= 1'b0;
      unsigned_q    <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'b0;
      mem_req_wen   <= 1'b0;
      mem_req_wmask <= 4'b0;
      mem_req_wdata <= 32'b0;
      out_valid     <= 1'b0;
      out_wen       <= 1'b0;
      out_rd        <= 4'b0;
      out_rdata     <= 32'b0;
      out_err       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            load_q     <= in_load;
            unsigned_q <= in_unsigned;
            size_q     <= in_size;
            off_q      <= in_addr[1:0];
            out_rd     <= in_rd;
            if (!in_load && !in_store) begin
              out_rdata <= in_addr;
              out_wen   <= (in_rd != 4'd0);
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else if (misaligned) begin
              out_rdata <= in_addr;
              out_wen   <= 1'b0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wen   <= in_store;
              mem_req_wmask <= in_store ? lane_mask : 4'b0000;
              mem_req_wdata <= lane_wdata;
              state_q       <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (mem_resp_valid) begin
            out_rdata <= load_q ? load_data : 32'b0;
            out_wen   <= load_q && (out_rd != 4'd0);
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110026_lsu.sv
// Directed self-checking bench for the LSU: forwarding, loads, stores, errors, stalls, reset.
`timescale 1ns/1ps
module tb_ysyx_24110026_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [3:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [3:0]  out_rd;
  logic [31:0] out_rdata;
  logic        out_err;

  int checks;
  int errors;
  int hs_cnt;

  ysyx_24110026_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_load        (in_load),
    .in_store       (in_store),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wen        (out_wen),
    .out_rd         (out_rd),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] rd);
    @(negedge clk);
    in_valid    = 1'b1;
    in_load     = ld;
    in_store    = st;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wd;
    in_rd       = rd;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_store = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic wen, input logic [31:0] data,
                           input logic err, input logic [3:0] rd);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_wen"}, 32'(out_wen), 32'(wen));
    chk({tag, "_rdata"}, out_rdata, data);
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wd, input logic wen);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, mem_req_addr, addr);
    chk({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'(mask));
    chk({tag, "_req_wdata"}, mem_req_wdata, wd);
    chk({tag, "_req_wen"}, 32'(mem_req_wen), 32'(wen));
  endtask

  // Called on the falling edge right after the accepting edge.
  task automatic mem_txn(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, input logic wen, input logic [31:0] rdata,
                         input int req_stall, input int out_stall, input logic owen,
                         input logic [31:0] odata, input logic [3:0] rd);
    int hs0;
    hs0 = hs_cnt;
    mem_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      check_req({tag, "_stall"}, addr, mask, wd, wen);
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check_req(tag, addr, mask, wd, wen);
    mem_req_ready  = 1'b1;
    // Response during the request handshake must be ignored.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = ~rdata;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    chk({tag, "_req_dropped"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_no_out_yet"}, 32'(out_valid), 32'd0);
    mem_resp_rdata = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    out_ready      = (out_stall == 0);
    for (int i = 0; i < out_stall; i++) begin
      check_out({tag, "_ostall"}, owen, odata, 1'b0, rd);
      chk({tag, "_ostall_in_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_out(tag, owen, odata, 1'b0, rd);
    @(negedge clk);
    chk({tag, "_out_done"}, 32'(out_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; hs_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; in_addr = 32'b0; in_wdata = 32'b0; in_rd = 4'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'b0; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Forward ALU result
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 4'd5);
    chk("fwd_no_req", 32'(mem_req_valid), 32'd0);
    check_out("fwd", 1'b1, 32'h0000_1234, 1'b0, 4'd5);
    @(negedge clk);
    chk("fwd_done", 32'(out_valid), 32'd0);

    // Forward to x0: data reported, no write
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_00AA, 32'h0, 4'd0);
    check_out("fwd_x0", 1'b0, 32'h0000_00AA, 1'b0, 4'd0);

    // LB / LBU at the top byte lane
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 4'd6);
    mem_txn("lb", 32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h80FF_1122, 0, 0, 1'b1,
            32'hFFFF_FF80, 4'd6);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 4'd6);
    mem_txn("lbu", 32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h80FF_1122, 0, 0, 1'b1,
            32'h0000_0080, 4'd6);

    // LH upper half, sign-extended
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 4'd2);
    mem_txn("lh", 32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h8001_0000, 0, 0, 1'b1,
            32'hFFFF_8001, 4'd2);

    // SH upper half, SB lane 1
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'hDEAD_BEEF, 4'd7);
    mem_txn("sh", 32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0, 0, 0, 1'b0,
            32'h0, 4'd7);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0105, 32'h0000_00A5, 4'd1);
    mem_txn("sb", 32'h8000_0104, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0, 0, 0, 1'b0,
            32'h0, 4'd1);

    // Misaligned LW and reserved size
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 4'd4);
    chk("mis_no_req", 32'(mem_req_valid), 32'd0);
    check_out("mis_lw", 1'b0, 32'h8000_0001, 1'b1, 4'd4);
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h1, 4'd4);
    chk("rsv_no_req", 32'(mem_req_valid), 32'd0);
    check_out("rsv", 1'b0, 32'h8000_0000, 1'b1, 4'd4);

    // Back-pressure on both sides
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0008, 32'h0, 4'd3);
    mem_txn("bp", 32'h8000_0008, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D, 3, 2, 1'b1,
            32'hCAFE_F00D, 4'd3);

    // Reset while waiting for the response
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 4'd9);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_req_addr", mem_req_addr, 32'd0);
    chk("rst_mid_out_rd", 32'(out_rd), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0BAD;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("late_resp_out_valid", 32'(out_valid), 32'd0);
    chk("late_resp_req_valid", 32'(mem_req_valid), 32'd0);
    chk("late_resp_in_ready", 32'(in_ready), 32'd1);
    mem_resp_valid = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 4'd8);
    mem_txn("lw_after_rst", 32'h8000_0004, 4'b0000, 32'h0, 1'b0, 32'h1234_5678, 0, 0, 1'b1,
            32'h1234_5678, 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
